// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall/bubble, jump squash, and syscall drain/notify sequencing.
// STALL/FLUSH are combinational from state and inputs; Busy/Syscall_OUT come straight from flops.
module hazard_ctrl #(
   parameter int NSTAGES = 4,
   parameter int REGW    = 5
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               Syscall_IN,
   input  logic               Syscall_ACK,
   input  logic               Jump_IN,
   input  logic               MemRead_IDEXE,
   input  logic [REGW-1:0]    Rt_IDEXE,
   input  logic [REGW-1:0]    Rs_IFID,
   input  logic [REGW-1:0]    Rt_IFID,
   output logic [NSTAGES-1:0] STALL,
   output logic [NSTAGES-1:0] FLUSH,
   output logic               Syscall_OUT,
   output logic               Busy
);

   localparam int IDXW = $clog2(NSTAGES) + 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSTAGES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAIN  = 2'd1,
      S_NOTIFY = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            busy_q, sysout_q;
   logic            loaduse;

   // Register 0 is hardwired zero, so a load targeting it can never create a hazard.
   assign loaduse = MemRead_IDEXE && (Rt_IDEXE != '0) &&
                    ((Rt_IDEXE == Rs_IFID) || (Rt_IDEXE == Rt_IFID));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (Syscall_IN) begin
               state_d = S_DRAIN;
               idx_d   = IDXW'(1);
            end
         end
         S_DRAIN: begin
            if (idx_q == IDX_LAST) begin
               state_d = S_NOTIFY;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         S_NOTIFY: begin
            if (Syscall_ACK) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Busy and Syscall_OUT are flopped from the next state so they never glitch.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         sysout_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         busy_q   <= (state_d != S_IDLE);
         sysout_q <= (state_d == S_NOTIFY);
      end
   end

   always_comb begin
      STALL = '0;
      FLUSH = '0;
      case (state_q)
         S_IDLE: begin
            if (loaduse) begin
               STALL[0] = 1'b1;
               FLUSH[1] = 1'b1;
            end else if (Jump_IN) begin
               FLUSH[0] = 1'b1;
            end
         end
         S_DRAIN: begin
            STALL[0] = 1'b1;
            FLUSH[0] = 1'b1;
            for (int i = 1; i < NSTAGES; i++) begin
               if (idx_q == IDXW'(i)) FLUSH[i] = 1'b1;
            end
         end
         S_NOTIFY: begin
            STALL[0] = 1'b1;
            FLUSH[0] = 1'b1;
         end
         default: begin
            STALL = '0;
            FLUSH = '0;
         end
      endcase
   end

   assign Busy        = busy_q;
   assign Syscall_OUT = sysout_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NSTAGES, default 4: number of pipeline registers (index 0 = IFID, 1 = IDEXE, 2 = EXEMEM, 3 = MEMWB); legal range 2..8.
REQ-002 Parameter REGW, default 5: register-specifier width.
REQ-003 Port CLOCK, input, 1: single clock; all state updates on posedge.
REQ-004 Port RESET, input, 1: asynchronous, active-low reset.
REQ-005 Port Syscall_IN, input, 1: a syscall has been decoded.
REQ-006 Port Syscall_ACK, input, 1: the handler has finished servicing the syscall.
REQ-007 Port Jump_IN, input, 1: a taken jump or branch has been resolved in ID.
REQ-008 Port MemRead_IDEXE, input, 1: the instruction in IDEXE is a load.
REQ-009 Port Rt_IDEXE, input, REGW: load destination register.
REQ-010 Ports Rs_IFID and Rt_IFID, input, REGW each: source registers of the instruction in IFID.
REQ-011 Port STALL, output, NSTAGES: per-stage hold; STALL[0] also freezes the PC.
REQ-012 Port FLUSH, output, NSTAGES: per-stage bubble insert.
REQ-013 Port Syscall_OUT, output, 1: the pipeline is drained and the syscall awaits service.
REQ-014 Port Busy, output, 1: the unit is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRAIN and NOTIFY, with a drain index idx of width clog2(NSTAGES)+1.
REQ-016 loaduse SHALL be MemRead_IDEXE & (Rt_IDEXE != 0) & (Rt_IDEXE == Rs_IFID | Rt_IDEXE == Rt_IFID), decoded combinationally.
REQ-017 In IDLE with loaduse=1, STALL[0]=1 and FLUSH[1]=1 in the same cycle, with no state change.
REQ-018 In IDLE with Jump_IN=1 and loaduse=0, FLUSH[0]=1 in the same cycle.
REQ-019 In IDLE with Jump_IN=1 and loaduse=1, the load-use response SHALL win; FLUSH[0]=0, and the jump is re-presented by the pipeline the next cycle.
REQ-020 On a posedge in IDLE with Syscall_IN=1, the FSM SHALL go to DRAIN with idx=1; any load-use outputs in that same cycle still assert.
REQ-021 In DRAIN: STALL[0]=1, FLUSH[0]=1, FLUSH[idx]=1, and all other FLUSH bits are 0.
REQ-022 In DRAIN, idx SHALL increment by 1 per cycle; when idx==NSTAGES-1, the next state is NOTIFY. DRAIN therefore lasts exactly NSTAGES-1 cycles.
REQ-023 In NOTIFY: Syscall_OUT=1, STALL[0]=1, FLUSH[0]=1, and all other FLUSH bits are 0.
REQ-024 NOTIFY SHALL be held until Syscall_ACK=1 is sampled at a posedge; the next state is then IDLE with idx=0.
REQ-025 Syscall_ACK SHALL be accepted in the first NOTIFY cycle, and ignored outside NOTIFY.
REQ-026 Outside IDLE, Syscall_IN, Jump_IN and loaduse SHALL be ignored; no nested syscall is supported.
REQ-027 STALL[NSTAGES-1:1] SHALL be constant 0.
REQ-028 Busy SHALL be 1 in DRAIN and NOTIFY.
REQ-029 Syscall_OUT and Busy SHALL decode from registered state only and be glitch-free.
REQ-030 The IDLE-to-IDLE loop SHALL have zero added latency.

Reset
REQ-031 While RESET=0: state=IDLE, idx=0, Syscall_OUT=0, Busy=0; STALL/FLUSH=0 whenever loaduse=0 and Jump_IN=0.
REQ-032 Reset asserted mid-DRAIN or mid-NOTIFY SHALL abort immediately to IDLE with no pending syscall.
REQ-033 Release of reset is synchronous-safe: the first posedge after RESET rises evaluates from IDLE.

Verification (NSTAGES=4)
REQ-034 Stimulus: MemRead_IDEXE=1, Rt_IDEXE=8, Rs_IFID=8, one cycle. Required: STALL=0001 and FLUSH=0010 that cycle; all zero the next cycle.
REQ-035 Stimulus: Rt_IDEXE=0 matching Rs_IFID=0 with MemRead_IDEXE=1. Required: STALL=0000 and FLUSH=0000.
REQ-036 Stimulus: Syscall_IN pulse. Required, over the following cycles: FLUSH=0011, then 0101, then 1001; then Syscall_OUT=1 with FLUSH=0001 until Syscall_ACK; IDLE on the cycle after ACK.
REQ-037 Stimulus: Jump_IN=1 together with a load-use hit. Required: FLUSH=0010 and STALL=0001 (no FLUSH[0]).
REQ-038 Stimulus: RESET=0 asserted during the second DRAIN cycle. Required: Busy=0 and Syscall_OUT=0 immediately; no NOTIFY afterward.
REQ-039 Stimulus: Syscall_IN pulsed again during NOTIFY, and ACK delayed by 5 cycles. Required: the second pulse is ignored; Syscall_OUT is held for 5 cycles, then the FSM returns to IDLE once.
